am_error_stats_sweep: RTL and testbench

//  Exhaustive error characterisation stage, sitting downstream of an approximate

---
 rtl/am_error_stats_sweep.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_am_error_stats_sweep.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/am_error_stats_sweep.sv
// Exhaustive error-statistics sweep for an approximate NxN unsigned multiplier.
// Optional signed bias accumulator output enabled by defining AM_ERR_BIAS_EN.
module am_error_stats_sweep #(
    parameter int N     = 8,
    parameter int SQ_W  = 48,
    parameter int ABS_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [N-1:0]       mul_x,
    output logic [N-1:0]       mul_y,
    input  logic [2*N-1:0]     mul_z,
    output logic [SQ_W-1:0]    err_sum_sq,
    output logic [ABS_W-1:0]   err_sum_abs,
    output logic [2*N-1:0]     err_max,
    output logic [2*N:0]       err_count,
    output logic [N-1:0]       worst_x,
    output logic [N-1:0]       worst_y
`ifdef AM_ERR_BIAS_EN
    ,
    output logic signed [4*N+1:0] err_sum_signed
`endif
);

    localparam int W   = 2 * N;
    localparam int P_W = 4 * N;
    localparam logic [N-1:0] N_ONE   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [W:0]   CNT_ONE = {{W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_r;
    state_t state_s;
    logic   start_go_s;
    logic   done_go_s;
    logic   flush_s;
    logic   last_pair_s;

    logic [N-1:0] mul_x_r;
    logic [N-1:0] mul_y_r;

    logic                s1_v_r;
    logic [N-1:0]        s1_x_r;
    logic [N-1:0]        s1_y_r;
    logic [W-1:0]        s1_z_r;
    logic [W-1:0]        s1_p_r;

    logic                s2_v_r;
    logic [N-1:0]        s2_x_r;
    logic [N-1:0]        s2_y_r;
    logic signed [W:0]   s2_d_r;
    logic [W-1:0]        s2_abs_r;

    logic                s3_v_r;
    logic                s3_gt_r;
    logic [N-1:0]        s3_x_r;
    logic [N-1:0]        s3_y_r;
    logic signed [W:0]   s3_d_r;
    logic [W-1:0]        s3_abs_r;
    logic [P_W-1:0]      s3_sq_r;

    logic signed [W:0]   d_s;
    logic signed [W:0]   neg_d_s;
    logic [W-1:0]        abs_s;
    logic [P_W-1:0]      sq_s;
    logic [W-1:0]        max_fwd_s;
    logic [W-1:0]        prod_s;

    logic [SQ_W-1:0]     sum_sq_r;
    logic [ABS_W-1:0]    sum_abs_r;
    logic [W-1:0]        max_r;
    logic [W:0]          count_r;
    logic [N-1:0]        worst_x_r;
    logic [N-1:0]        worst_y_r;
    logic                busy_r;
    logic                done_r;
`ifdef AM_ERR_BIAS_EN
    logic signed [P_W+1:0] sum_signed_r;
`endif

    logic [SQ_W:0]       sum_sq_ext_s;
    logic [ABS_W:0]      sum_abs_ext_s;
    logic [SQ_W-1:0]     sum_sq_nx_s;
    logic [ABS_W-1:0]    sum_abs_nx_s;
    logic [W:0]          count_nx_s;

    assign last_pair_s = (mul_x_r == {N{1'b1}}) && (mul_y_r == {N{1'b1}});

    // Next-state and control strobes; abort dominates start
    always_comb begin
        state_s    = state_r;
        start_go_s = 1'b0;
        done_go_s  = 1'b0;
        flush_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start && !abort) begin
                    state_s    = ST_SWEEP;
                    start_go_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SWEEP: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    flush_s = 1'b1;
                end else if (last_pair_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_SWEEP;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    flush_s = 1'b1;
                end else if (!s1_v_r && !s2_v_r) begin
                    // last pair is in S3 and lands in the accumulators on this edge
                    state_s   = ST_DONE;
                    done_go_s = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_SWEEP) || (state_s == ST_DRAIN);
            done_r  <= done_go_s;
        end
    end

    // Operand sequencer: x inner loop, y outer loop, holds outside SWEEP
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_x_r <= '0;
            mul_y_r <= '0;
        end else if (start_go_s) begin
            mul_x_r <= '0;
            mul_y_r <= '0;
        end else if ((state_r == ST_SWEEP) && !abort && !last_pair_s) begin
            if (mul_x_r == {N{1'b1}}) begin
                mul_x_r <= '0;
                mul_y_r <= mul_y_r + N_ONE;
            end else begin
                mul_x_r <= mul_x_r + N_ONE;
            end
        end
    end

    // Datapath arithmetic; S3 compares against err_max including the pair now in S4
    always_comb begin
        prod_s    = {{N{1'b0}}, mul_x_r} * {{N{1'b0}}, mul_y_r};
        d_s       = $signed({1'b0, s1_z_r}) - $signed({1'b0, s1_p_r});
        neg_d_s   = -d_s;
        abs_s     = d_s[W] ? neg_d_s[W-1:0] : d_s[W-1:0];
        sq_s      = {{W{1'b0}}, s2_abs_r} * {{W{1'b0}}, s2_abs_r};
        max_fwd_s = (s3_v_r && s3_gt_r) ? s3_abs_r : max_r;
    end

    // Three-stage pipeline registers feeding the accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_r   <= 1'b0;
            s1_x_r   <= '0;
            s1_y_r   <= '0;
            s1_z_r   <= '0;
            s1_p_r   <= '0;
            s2_v_r   <= 1'b0;
            s2_x_r   <= '0;
            s2_y_r   <= '0;
            s2_d_r   <= '0;
            s2_abs_r <= '0;
            s3_v_r   <= 1'b0;
            s3_gt_r  <= 1'b0;
            s3_x_r   <= '0;
            s3_y_r   <= '0;
            s3_d_r   <= '0;
            s3_abs_r <= '0;
            s3_sq_r  <= '0;
        end else begin
            s1_v_r   <= (state_r == ST_SWEEP) && !flush_s;
            s1_x_r   <= mul_x_r;
            s1_y_r   <= mul_y_r;
            s1_z_r   <= mul_z;
            s1_p_r   <= prod_s;
            s2_v_r   <= s1_v_r && !flush_s;
            s2_x_r   <= s1_x_r;
            s2_y_r   <= s1_y_r;
            s2_d_r   <= d_s;
            s2_abs_r <= abs_s;
            s3_v_r   <= s2_v_r && !flush_s;
            s3_gt_r  <= s2_v_r && (s2_abs_r > max_fwd_s);
            s3_x_r   <= s2_x_r;
            s3_y_r   <= s2_y_r;
            s3_d_r   <= s2_d_r;
            s3_abs_r <= s2_abs_r;
            s3_sq_r  <= sq_s;
        end
    end

    // Saturating next values for the accumulators
    always_comb begin
        sum_sq_ext_s  = {1'b0, sum_sq_r} + (SQ_W+1)'(s3_sq_r);
        sum_abs_ext_s = {1'b0, sum_abs_r} + (ABS_W+1)'(s3_abs_r);
        sum_sq_nx_s   = sum_sq_ext_s[SQ_W] ? {SQ_W{1'b1}} : sum_sq_ext_s[SQ_W-1:0];
        sum_abs_nx_s  = sum_abs_ext_s[ABS_W] ? {ABS_W{1'b1}} : sum_abs_ext_s[ABS_W-1:0];
        if ((s3_abs_r != '0) && (count_r != {(W+1){1'b1}})) begin
            count_nx_s = count_r + CNT_ONE;
        end else begin
            count_nx_s = count_r;
        end
    end

    // S4 accumulators; worst pair updates only on a strictly larger error
    always_ff @(posedge clk) begin
        if (rst || start_go_s) begin
            sum_sq_r  <= '0;
            sum_abs_r <= '0;
            max_r     <= '0;
            count_r   <= '0;
            worst_x_r <= '0;
            worst_y_r <= '0;
        end else if (s3_v_r && !flush_s) begin
            sum_sq_r  <= sum_sq_nx_s;
            sum_abs_r <= sum_abs_nx_s;
            count_r   <= count_nx_s;
            if (s3_gt_r) begin
                max_r     <= s3_abs_r;
                worst_x_r <= s3_x_r;
                worst_y_r <= s3_y_r;
            end
        end
    end

`ifdef AM_ERR_BIAS_EN
    // Signed bias sum; width covers the full sweep so no saturation is needed
    always_ff @(posedge clk) begin
        if (rst || start_go_s) begin
            sum_signed_r <= '0;
        end else if (s3_v_r && !flush_s) begin
            sum_signed_r <= sum_signed_r + (P_W+2)'(s3_d_r);
        end
    end

    assign err_sum_signed = sum_signed_r;
`endif

    assign busy        = busy_r;
    assign done        = done_r;
    assign mul_x       = mul_x_r;
    assign mul_y       = mul_y_r;
    assign err_sum_sq  = sum_sq_r;
    assign err_sum_abs = sum_abs_r;
    assign err_max     = max_r;
    assign err_count   = count_r;
    assign worst_x     = worst_x_r;
    assign worst_y     = worst_y_r;

endmodule

// File: tb/tb_am_error_stats_sweep.sv
// Scoreboard bench for am_error_stats_sweep at N=4 with narrowed sum widths so
// saturation is reachable; expectations come from a whole-sweep reference model.
module tb_am_error_stats_sweep;

    localparam int N     = 4;
    localparam int SQ_W  = 20;
    localparam int ABS_W = 12;
    localparam int SIDE  = 1 << N;
    localparam int PAIRS = 1 << (2 * N);
    localparam int LAT   = PAIRS + 4;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic busy, done;
    logic [N-1:0]     mul_x, mul_y;
    logic [2*N-1:0]   mul_z;
    logic [SQ_W-1:0]  err_sum_sq;
    logic [ABS_W-1:0] err_sum_abs;
    logic [2*N-1:0]   err_max;
    logic [2*N:0]     err_count;
    logic [N-1:0]     worst_x, worst_y;
`ifdef AM_ERR_BIAS_EN
    logic signed [4*N+1:0] err_sum_signed;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int           mode = 0;
    logic [2*N-1:0] lut [PAIRS];
    logic [2*N-1:0] trunc_mask = '0;

    typedef struct {
        longint sq;
        longint ab;
        longint mx;
        longint cnt;
        longint wx;
        longint wy;
        longint bias;
        int     done_cyc;
    } exp_t;

    exp_t q[$];
    exp_t last_e;

    // Candidate multipliers: 0 exact, 1 stuck at zero, 2 off by one, 3 random xor, 4 truncating
    function automatic logic [2*N-1:0] ref_z(int m, int x, int y, logic [2*N-1:0] l, logic [2*N-1:0] msk);
        logic [2*N-1:0] p;
        p = 2*N'(x * y);
        case (m)
            0: return p;
            1: return '0;
            2: return 2*N'(x * y + 1);
            3: return p ^ l;
            default: return p & ~msk;
        endcase
    endfunction

    assign mul_z = ref_z(mode, int'(mul_x), int'(mul_y), lut[{mul_y, mul_x}], trunc_mask);

    function automatic exp_t model(int m, int s_cyc);
        exp_t e;
        longint d, a;
        e = '{default: 0};
        for (int y = 0; y < SIDE; y++) begin
            for (int x = 0; x < SIDE; x++) begin
                d = longint'(ref_z(m, x, y, lut[y * SIDE + x], trunc_mask)) - longint'(x * y);
                a = (d < 0) ? -d : d;
                e.sq   += a * a;
                e.ab   += a;
                e.bias += d;
                if (a != 0) e.cnt++;
                if (a > e.mx) begin
                    e.mx = a;
                    e.wx = x;
                    e.wy = y;
                end
            end
        end
        if (e.sq > (64'sd1 << SQ_W) - 1) e.sq = (64'sd1 << SQ_W) - 1;
        if (e.ab > (64'sd1 << ABS_W) - 1) e.ab = (64'sd1 << ABS_W) - 1;
        e.done_cyc = s_cyc + LAT;
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    am_error_stats_sweep #(.N(N), .SQ_W(SQ_W), .ABS_W(ABS_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
        .err_sum_sq(err_sum_sq), .err_sum_abs(err_sum_abs),
        .err_max(err_max), .err_count(err_count),
        .worst_x(worst_x), .worst_y(worst_y)
`ifdef AM_ERR_BIAS_EN
        , .err_sum_signed(err_sum_signed)
`endif
    );

    // Monitor: every done pulse is matched against the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                last_e = q.pop_front();
                chk("done_cycle",  cyc,         last_e.done_cyc);
                chk("busy_at_done", busy,       0);
                chk("err_sum_sq",  err_sum_sq,  last_e.sq);
                chk("err_sum_abs", err_sum_abs, last_e.ab);
                chk("err_max",     err_max,     last_e.mx);
                chk("err_count",   err_count,   last_e.cnt);
                chk("worst_x",     worst_x,     last_e.wx);
                chk("worst_y",     worst_y,     last_e.wy);
`ifdef AM_ERR_BIAS_EN
                chk("err_sum_signed", longint'(err_sum_signed), last_e.bias);
`endif
            end
        end
    end

    task automatic do_start(input int m);
        mode = m;
        @(posedge clk); #1;
        start = 1'b1;
        q.push_back(model(m, cyc));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        int k = 0;
        while (k < LAT + 20 && !seen) begin
            @(negedge clk);
            seen = done;
            k++;
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        chk({tag, "_busy"},  busy,        0);
        chk({tag, "_done"},  done,        0);
        chk({tag, "_mul_x"}, mul_x,       0);
        chk({tag, "_mul_y"}, mul_y,       0);
        chk({tag, "_sq"},    err_sum_sq,  0);
        chk({tag, "_abs"},   err_sum_abs, 0);
        chk({tag, "_max"},   err_max,     0);
        chk({tag, "_count"}, err_count,   0);
        chk({tag, "_wx"},    worst_x,     0);
        chk({tag, "_wy"},    worst_y,     0);
`ifdef AM_ERR_BIAS_EN
        chk({tag, "_bias"}, longint'(err_sum_signed), 0);
`endif
    endtask

    initial begin
        int n_done;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        for (int i = 0; i < PAIRS; i++) begin
            lut[i] = ($urandom_range(0, 3) == 0) ? 2*N'($urandom_range(1, 15)) : '0;
        end
        trunc_mask = 2*N'($urandom_range(1, 7));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset");

        // One full sweep per candidate, then confirm the results hold
        for (int m = 0; m < 5; m++) begin
            do_start(m);
            wait_done();
            repeat (3) @(negedge clk);
            chk("hold_done",  done,       0);
            chk("hold_sq",    err_sum_sq, last_e.sq);
            chk("hold_max",   err_max,    last_e.mx);
            chk("hold_count", err_count,  last_e.cnt);
        end

        // Reset in the middle of a sweep, then a clean restart
        do_start(1);
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete(q.size() - 1);
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("midrst");
        do_start(2);
        wait_done();

        // Start pulses while busy must not disturb the sweep
        do_start(3);
        repeat (3) begin
            repeat ($urandom_range(10, 60)) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_done();

        // Start together with abort: sweep stops, no done pulse
        do_start(4);
        repeat (40) @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        q.delete(q.size() - 1);
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        n_done = 0;
        for (int k = 0; k < LAT + 10; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", n_done, 0);

        // Back-to-back sweeps: restart in the done cycle
        do_start(3);
        wait_done();
        start = 1'b1;
        q.push_back(model(3, cyc));
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();

        repeat (5) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
